// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART TX arbiter slice.
package uart_pkg;

   localparam int unsigned UART_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_ACK,
      WAIT_DONE
   } arb_state_e;

   // Width of a requester index; never narrower than one bit.
   function automatic int unsigned grant_w(input int unsigned n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request above the pointer, wrapping.
module rr_picker
   import uart_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]          req_i,
   input  logic [grant_w(NUM_REQ)-1:0] ptr_i,
   output logic [grant_w(NUM_REQ)-1:0] winner_o,
   output logic                        any_req_o
);

   localparam int unsigned GW = grant_w(NUM_REQ);

   // Walk from the farthest slot back to ptr+1 so the nearest hit is written last.
   always_comb begin
      winner_o = '0;
      for (int off = int'(NUM_REQ); off >= 1; off--) begin
         if (req_i[(int'(ptr_i) + off) % int'(NUM_REQ)]) begin
            winner_o = GW'((int'(ptr_i) + off) % int'(NUM_REQ));
         end
      end
   end

   assign any_req_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, burst-locking arbiter sharing one UART transmitter between NUM_REQ byte sources.
// Optional statistics outputs (tx_count, rotate_forced) under UART_TX_ARBITER_STATS_EN.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned MAX_BURST = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]             req_last,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [UART_DATA_W-1:0]         tx_data,
   output logic                           tx_start,
   input  logic                           tx_busy,
   output logic [grant_w(NUM_REQ)-1:0]    grant_id,
   output logic                           grant_active
`ifdef UART_TX_ARBITER_STATS_EN
   ,
   output logic [15:0]                    tx_count,
   output logic                           rotate_forced
`endif
);

   localparam int unsigned GW      = grant_w(NUM_REQ);
   localparam int unsigned BURST_W = 8;

   arb_state_e             state_q, state_d;
   logic [GW-1:0]          grant_q, grant_d;
   logic [GW-1:0]          ptr_q, ptr_d;
   logic                   active_q, active_d;
   logic [BURST_W-1:0]     burst_q, burst_d;
   logic                   last_q, last_d;
   logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
   logic                   tx_start_q, tx_start_d;
   logic                   rel;

   logic [GW-1:0]          pick_id;
   logic                   pick_any;
   logic                   own_valid;
   logic                   own_last;
   logic [UART_DATA_W-1:0] own_data;
   logic                   burst_done;

   rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .req_i     (req_valid),
      .ptr_i     (ptr_q),
      .winner_o  (pick_id),
      .any_req_o (pick_any)
   );

   // Select the current owner's request lane.
   always_comb begin
      own_valid = 1'b0;
      own_last  = 1'b0;
      own_data  = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (grant_q == GW'(i)) begin
            own_valid = req_valid[i];
            own_last  = req_last[i];
            own_data  = req_data[UART_DATA_W*i +: UART_DATA_W];
         end
      end
   end

   assign burst_done = (burst_q == BURST_W'(MAX_BURST));

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      ptr_d      = ptr_q;
      active_d   = active_q;
      burst_d    = burst_q;
      last_d     = last_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      req_ready  = '0;
      rel        = 1'b0;

      case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_d  = pick_id;
               active_d = 1'b1;
               burst_d  = '0;
               state_d  = SEND;
            end
         end
         SEND: begin
            if (!own_valid) begin
               rel = 1'b1;
            end else if (!tx_busy) begin
               req_ready  = NUM_REQ'(1) << grant_q;
               tx_data_d  = own_data;
               tx_start_d = 1'b1;
               last_d     = own_last;
               burst_d    = burst_q + 8'd1;
               state_d    = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (tx_busy) begin
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               if (last_q || burst_done) begin
                  rel = 1'b1;
               end else begin
                  state_d = SEND;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Releasing owner becomes the pointer, giving it lowest priority next round.
      if (rel) begin
         ptr_d    = grant_q;
         active_d = 1'b0;
         state_d  = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         ptr_q      <= GW'(NUM_REQ - 1);
         active_q   <= 1'b0;
         burst_q    <= '0;
         last_q     <= 1'b0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         ptr_q      <= ptr_d;
         active_q   <= active_d;
         burst_q    <= burst_d;
         last_q     <= last_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
      end
   end

   assign tx_data      = tx_data_q;
   assign tx_start     = tx_start_q;
   assign grant_id     = grant_q;
   assign grant_active = active_q;

`ifdef UART_TX_ARBITER_STATS_EN
   logic [15:0] tx_count_q;
   logic        rotate_q;
   logic        forced_c;

   // A forced rotation is a release taken only because the burst limit was hit.
   assign forced_c = (state_q == WAIT_DONE) && !tx_busy && !last_q && burst_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_count_q <= '0;
         rotate_q   <= 1'b0;
      end else begin
         if (tx_start_d) begin
            tx_count_q <= tx_count_q + 16'd1;
         end
         rotate_q <= forced_c;
      end
   end

   assign tx_count      = tx_count_q;
   assign rotate_forced = rotate_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued byte sources, a busy-counter transmitter model, logged accepts/launches.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

   localparam int unsigned NR    = 4;
   localparam int unsigned MB    = 16;
   localparam int unsigned DEPTH = 32;
   localparam int unsigned LIMIT = 3000;

   logic            clk = 1'b0;
   logic            reset;
   logic [NR-1:0]   req_valid;
   logic [8*NR-1:0] req_data;
   logic [NR-1:0]   req_last;
   logic [NR-1:0]   req_ready;
   logic [7:0]      tx_data;
   logic            tx_start;
   logic            tx_busy;
   logic [1:0]      grant_id;
   logic            grant_active;
`ifdef UART_TX_ARBITER_STATS_EN
   logic [15:0]     tx_count;
   logic            rotate_forced;
`endif

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ   (NR),
      .MAX_BURST (MB)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .tx_data      (tx_data),
      .tx_start     (tx_start),
      .tx_busy      (tx_busy),
      .grant_id     (grant_id),
      .grant_active (grant_active)
`ifdef UART_TX_ARBITER_STATS_EN
      ,
      .tx_count      (tx_count),
      .rotate_forced (rotate_forced)
`endif
   );

   // Byte sources: ring of {last,data} per requester
   logic [8:0]  mem [NR][DEPTH];
   int unsigned rd_ptr [NR] = '{default: 0};
   int unsigned len [NR]    = '{default: 0};
   logic [NR-1:0] kill = '0;

   for (genvar g = 0; g < NR; g++) begin : g_src
      assign req_valid[g]         = (rd_ptr[g] < len[g]) && !kill[g];
      assign req_data[8*g +: 8]   = mem[g][rd_ptr[g] % DEPTH][7:0];
      assign req_last[g]          = mem[g][rd_ptr[g] % DEPTH][8];
   end

   // Transmitter model: busy for busy_len cycles starting the cycle after tx_start
   int unsigned busy_len = 10;
   int unsigned busy_cnt = 0;
   always @(posedge clk) begin
      if (tx_start) busy_cnt <= busy_len;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end
   assign tx_busy = (busy_cnt != 0);

   // Monitors
   int unsigned acc_q[$];
   int unsigned txb_q[$];
   int unsigned overlap_err = 0, stray_err = 0, busy_start_err = 0;
   int unsigned starts_since_rst = 0, forced_cnt = 0;

   always @(posedge clk) begin
      for (int i = 0; i < int'(NR); i++) begin
         if (req_valid[i] && req_ready[i]) begin
            rd_ptr[i] <= rd_ptr[i] + 1;
            acc_q.push_back((32'(i) << 8) | 32'(req_data[8*i +: 8]));
         end
      end
      if ($countones(req_ready) > 1) overlap_err++;
      if ((req_ready & ~(grant_active ? (NR'(1) << grant_id) : NR'(0))) != '0) stray_err++;
      if (tx_start && tx_busy) busy_start_err++;
      if (tx_start) txb_q.push_back(32'(tx_data));
      if (reset) starts_since_rst = 0;
      else if (tx_start) starts_since_rst++;
`ifdef UART_TX_ARBITER_STATS_EN
      if (rotate_forced) forced_cnt++;
`endif
   end

   int unsigned n_chk = 0, n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int i, input logic [7:0] d, input logic l);
      mem[i][len[i] % DEPTH] = {l, d};
      len[i]++;
   endtask

   function automatic logic drained();
      logic r = 1'b1;
      for (int i = 0; i < int'(NR); i++) if (rd_ptr[i] < len[i] && !kill[i]) r = 1'b0;
      return r;
   endfunction

   task automatic wait_idle(input string name);
      int unsigned t = 0;
      while (!(drained() && !grant_active && !tx_busy) && t < LIMIT) begin
         tick();
         t++;
      end
      check({name, "_idle_timeout"}, 32'(t >= LIMIT), 32'd0);
   endtask

   function automatic logic [31:0] qget(input int unsigned q[$], input int unsigned idx);
      if (idx < q.size()) return q[idx];
      return 32'hFFFF_FFFF;
   endfunction

   task automatic check_log(input string name, input int unsigned abase, input int unsigned tbase,
                            input int unsigned exp[$]);
      check({name, "_accepts"}, 32'(acc_q.size() - abase), 32'(exp.size()));
      check({name, "_starts"}, 32'(txb_q.size() - tbase), 32'(exp.size()));
      foreach (exp[k]) begin
         check($sformatf("%s_acc%0d", name, k), qget(acc_q, abase + k), exp[k]);
         check($sformatf("%s_tx%0d", name, k), qget(txb_q, tbase + k), exp[k] & 32'hFF);
      end
   endtask

   typedef struct {
      logic [3:0]  load;
      int unsigned n;
      logic [7:0]  order;
   } vec_t;

   initial begin
      vec_t        vt [6];
      int unsigned e[$];
      int unsigned ab, tb, t, early_err, f0;

      // Single-byte messages loaded at once; order[2k+:2] is the k-th expected owner
      vt[0] = '{4'b1111, 4, {2'd2, 2'd1, 2'd0, 2'd3}};
      vt[1] = '{4'b0011, 2, {2'd0, 2'd0, 2'd1, 2'd0}};
      vt[2] = '{4'b1001, 2, {2'd0, 2'd0, 2'd0, 2'd3}};
      vt[3] = '{4'b0110, 2, {2'd0, 2'd0, 2'd2, 2'd1}};
      vt[4] = '{4'b0101, 2, {2'd0, 2'd0, 2'd2, 2'd0}};
      vt[5] = '{4'b1000, 1, {2'd0, 2'd0, 2'd0, 2'd3}};

      reset = 1'b1;
      tick();
      tick();
      check("rst_grant_active", 32'(grant_active), 0);
      check("rst_grant_id", 32'(grant_id), 0);
      check("rst_tx_start", 32'(tx_start), 0);
      check("rst_tx_data", 32'(tx_data), 0);
      check("rst_req_ready", 32'(req_ready), 0);
      reset = 1'b0;
      tick();

      // Single requester, latency and release timing
      push(2, 8'h41, 1'b1);
      tick();
      check("t1_grant_id", 32'(grant_id), 2);
      check("t1_grant_active", 32'(grant_active), 1);
      check("t1_ready", 32'(req_ready), 32'b0100);
      check("t1_start_early", 32'(tx_start), 0);
      tick();
      check("t1_start", 32'(tx_start), 1);
      check("t1_data", 32'(tx_data), 32'h41);
      check("t1_ready_off", 32'(req_ready), 0);
      tick();
      check("t1_start_pulse", 32'(tx_start), 0);
      check("t1_busy", 32'(tx_busy), 1);
      t = 0;
      while (tx_busy && t < 50) begin tick(); t++; end
      check("t1_busy_timeout", 32'(t >= 50), 0);
      check("t1_held", 32'(grant_active), 1);
      tick();
      check("t1_released", 32'(grant_active), 0);
      check("t1_data_hold", 32'(tx_data), 32'h41);

      // Round-robin order table
      busy_len = 3;
      for (int v = 0; v < 6; v++) begin
         ab = acc_q.size();
         tb = txb_q.size();
         e  = {};
         for (int i = 0; i < int'(NR); i++) if (vt[v].load[i]) push(i, 8'(8'h30 + i), 1'b1);
         for (int k = 0; k < int'(vt[v].n); k++) begin
            e.push_back((32'(vt[v].order[2*k +: 2]) << 8) | (32'h30 + 32'(vt[v].order[2*k +: 2])));
         end
         wait_idle($sformatf("vec%0d", v));
         check_log($sformatf("vec%0d", v), ab, tb, e);
      end

      // All four continuously requesting single-byte messages
      ab = acc_q.size();
      tb = txb_q.size();
      e  = {};
      for (int i = 0; i < int'(NR); i++) begin
         push(i, 8'(8'h50 + i), 1'b1);
         push(i, 8'(8'h60 + i), 1'b1);
      end
      for (int i = 0; i < int'(NR); i++) e.push_back((32'(i) << 8) | (32'h50 + 32'(i)));
      for (int i = 0; i < int'(NR); i++) e.push_back((32'(i) << 8) | (32'h60 + 32'(i)));
      wait_idle("cont");
      check_log("cont", ab, tb, e);

      // Three-byte burst from 1 with 0 waiting
      push(0, 8'h0f, 1'b1);
      wait_idle("pre_burst");
      ab = acc_q.size();
      tb = txb_q.size();
      push(1, 8'h1a, 1'b0);
      push(1, 8'h1b, 1'b0);
      push(1, 8'h1c, 1'b1);
      push(1, 8'h1d, 1'b1);
      push(0, 8'h0a, 1'b1);
      t = 0;
      while (!tx_busy && t < 50) begin tick(); t++; end
      while (tx_busy && t < 50) begin tick(); t++; end
      check("burst_wait_timeout", 32'(t >= 50), 0);
      tick();
      check("burst_b2b_ready", 32'(req_ready), 32'b0010);
      wait_idle("burst");
      e = {32'h11a, 32'h11b, 32'h11c, 32'h00a, 32'h11d};
      check_log("burst", ab, tb, e);

      // MAX_BURST forced rotation
      ab = acc_q.size();
      tb = txb_q.size();
      f0 = forced_cnt;
      for (int k = 0; k < 20; k++) push(0, 8'(8'h80 + k), 1'b0);
      tick();
      check("maxb_first_owner", 32'(grant_id), 0);
      push(3, 8'h3c, 1'b1);
      wait_idle("maxb");
      e = {};
      for (int k = 0; k < 16; k++) e.push_back(32'h80 + 32'(k));
      e.push_back(32'h33c);
      for (int k = 16; k < 20; k++) e.push_back(32'h80 + 32'(k));
      check_log("maxb", ab, tb, e);
`ifdef UART_TX_ARBITER_STATS_EN
      check("maxb_rotate_forced", forced_cnt - f0, 1);
`endif

      // Owner drops valid in SEND with transmitter idle
      ab = acc_q.size();
      tb = txb_q.size();
      push(1, 8'h71, 1'b1);
      push(3, 8'h73, 1'b1);
      tick();
      check("drop_owner", 32'(grant_id), 1);
      kill[1] = 1'b1;
      #1;
      check("drop_no_ready", 32'(req_ready), 0);
      tick();
      check("drop_released", 32'(grant_active), 0);
      check("drop_no_start", 32'(tx_start), 0);
      tick();
      check("drop_next_active", 32'(grant_active), 1);
      check("drop_next_owner", 32'(grant_id), 3);
      wait_idle("drop_a");
      kill[1] = 1'b0;
      wait_idle("drop_b");
      e = {32'h373, 32'h171};
      check_log("drop", ab, tb, e);

      // Reset during WAIT_DONE
      busy_len = 10;
      ab = acc_q.size();
      tb = txb_q.size();
      push(2, 8'h92, 1'b1);
      t = 0;
      while (!tx_busy && t < 50) begin tick(); t++; end
      check("rst_wait_timeout", 32'(t >= 50), 0);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_active", 32'(grant_active), 0);
      check("mid_rst_grant_id", 32'(grant_id), 0);
      check("mid_rst_start", 32'(tx_start), 0);
      check("mid_rst_data", 32'(tx_data), 0);
      check("mid_rst_ready", 32'(req_ready), 0);
      check("mid_rst_tx_busy", 32'(tx_busy), 1);
`ifdef UART_TX_ARBITER_STATS_EN
      check("mid_rst_tx_count", 32'(tx_count), 0);
      check("mid_rst_rotate", 32'(rotate_forced), 0);
`endif
      push(1, 8'h55, 1'b1);
      early_err = 0;
      t = 0;
      while (tx_busy && t < 50) begin
         if (tx_start || req_ready != '0) early_err++;
         tick();
         t++;
      end
      check("post_rst_wait", early_err, 0);
      check("post_rst_ready", 32'(req_ready), 32'b0010);
      tick();
      check("post_rst_start", 32'(tx_start), 1);
      check("post_rst_data", 32'(tx_data), 32'h55);
      wait_idle("post_rst");
      e = {32'h292, 32'h155};
      check_log("post_rst", ab, tb, e);
`ifdef UART_TX_ARBITER_STATS_EN
      check("tx_count", 32'(tx_count), starts_since_rst);
`endif

      check("ready_overlap", overlap_err, 0);
      check("ready_non_owner", stray_err, 0);
      check("start_while_busy", busy_start_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
